poly_modadd_ctrl: RTL and testbench

//  Sequences one shared modadd instance over two N-coefficient Kyber polynomials:
//  C[i] = (A[i] + B[i]) mod Q for i = 0..N-1.

---
 rtl/kyber_pkg.sv | 17 +
 rtl/modadd.sv | 23 ++
 rtl/poly_modadd_ctrl.sv | 145 ++++++++++++++
 tb/tb_poly_modadd_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber parameters and the
// poly_modadd_ctrl sequencer state type.
package kyber_pkg;

  localparam int          LOGQ    = 12;
  localparam logic [12:0] Q_VALUE = 13'd3329;
  localparam int          N       = 256;
  localparam int          ADDR_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/modadd.sv
// Combinational modular adder:
// o_c = (i_a + i_b) mod Q for operands < Q.
module modadd #(
  parameter int            LOGQ    = 12,
  parameter logic [LOGQ:0] Q_VALUE = 13'd3329
) (
  input  logic [LOGQ-1:0] i_a,
  input  logic [LOGQ-1:0] i_b,
  output logic [LOGQ-1:0] o_c
);

  logic [LOGQ:0] w_sum;
  logic          w_ge;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_ge  = (w_sum >= Q_VALUE);

  // One conditional subtraction suffices
  // because the sum is below 2*Q.
  assign o_c = LOGQ'(w_ge ? (w_sum - Q_VALUE)
                          : w_sum);

endmodule

// File: rtl/poly_modadd_ctrl.sv
// Streams C[i] = (A[i]+B[i]) mod Q over one
// polynomial, one coefficient per cycle.
module poly_modadd_ctrl
  import kyber_pkg::*;
#(
  parameter int            LOGQ    = kyber_pkg::LOGQ,
  parameter logic [LOGQ:0] Q_VALUE = kyber_pkg::Q_VALUE,
  parameter int            N       = kyber_pkg::N,
  parameter int            ADDR_W  = kyber_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [LOGQ-1:0]   a_data,
  input  logic [LOGQ-1:0]   b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LOGQ-1:0]   wr_data
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(N - 1);

  state_t            r_state;
  logic              r_drain;
  logic              r_start_q;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_v1;
  logic [ADDR_W-1:0] r_idx1;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [LOGQ-1:0]   r_wr_data;
  logic [LOGQ-1:0]   w_sum;
  logic              w_go;

  // A start held high counts as a single
  // request: only its rising edge is taken.
  assign w_go = start & ~r_start_q;

  // Sequencer: issues N reads, drains the
  // pipeline, then pulses done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_drain   <= 1'b0;
      r_start_q <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_start_q <= start;
      r_done    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_rd_addr <= '0;
          if (w_go) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b1;
          end
        end
        RUN: begin
          // Stop on the last index so a full
          // 2**ADDR_W range never wraps.
          if (r_rd_addr == LAST) begin
            r_state <= DRAIN;
            r_rd_en <= 1'b0;
            r_drain <= 1'b0;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (r_drain) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_rd_addr <= '0;
        end
      endcase
    end
  end

  modadd #(
    .LOGQ    (LOGQ),
    .Q_VALUE (Q_VALUE)
  ) u_modadd (
    .i_a (a_data),
    .i_b (b_data),
    .o_c (w_sum)
  );

  // s1: track which index the RAM data
  // arriving this cycle belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_idx1 <= '0;
    end else begin
      r_v1 <= r_rd_en;
      if (r_rd_en) begin
        r_idx1 <= r_rd_addr;
      end
    end
  end

  // s2: register the sum for the result RAM;
  // address and data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= r_v1;
      if (r_v1) begin
        r_wr_addr <= r_idx1;
        r_wr_data <= w_sum;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_poly_modadd_ctrl.sv
// Self-checking bench for poly_modadd_ctrl:
// scoreboarded runs plus an N=4 build.
module tb_poly_modadd_ctrl;
  import kyber_pkg::*;

  localparam int TN = 256;
  localparam int QI = 3329;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, rd_en, wr_en;
  logic [7:0]  rd_addr, wr_addr;
  logic [11:0] a_data = '0, b_data = '0;
  logic [11:0] wr_data;

  logic        start4 = 1'b0;
  logic        busy4, done4, rd_en4, wr_en4;
  logic [1:0]  rd_addr4, wr_addr4;
  logic [11:0] a_data4 = '0, b_data4 = '0;
  logic [11:0] wr_data4;

  logic [11:0] mem_a [TN];
  logic [11:0] mem_b [TN];
  logic [11:0] mem_e [TN];
  logic [11:0] res   [TN];

  typedef struct {
    logic [7:0]  addr;
    logic [11:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] e;
  } vec_t;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, c0 = 0;
  bit mon = 1'b0;
  int n_rd, n_wr, n_done, n_busy;
  int busy_first, busy_last, done_rel;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= mem_a[rd_addr];
      b_data <= mem_b[rd_addr];
    end
    if (rd_en4) begin
      a_data4 <= mem_a[rd_addr4];
      b_data4 <= mem_b[rd_addr4];
    end
  end

  poly_modadd_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .a_data  (a_data),
    .b_data  (b_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  poly_modadd_ctrl #(
    .N      (4),
    .ADDR_W (2)
  ) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start4),
    .busy    (busy4),
    .done    (done4),
    .rd_en   (rd_en4),
    .rd_addr (rd_addr4),
    .a_data  (a_data4),
    .b_data  (b_data4),
    .wr_en   (wr_en4),
    .wr_addr (wr_addr4),
    .wr_data (wr_data4)
  );

  task automatic chk(input string nm, input bit ok,
                     input longint act,
                     input longint req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, req);
    end
  endtask

  task automatic clr_mon();
    n_rd = 0; n_wr = 0; n_done = 0; n_busy = 0;
    busy_first = -1; busy_last = -1;
    done_rel = -1;
    sbq.delete();
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (mon) begin
      if (rd_en) begin
        sbq.push_back('{rd_addr, mem_e[rd_addr], cyc});
        n_rd++;
      end
      if (wr_en) begin
        n_wr++;
        if (sbq.size() == 0) begin
          chk("wr_spurious", 1'b0, wr_addr, -1);
        end else begin
          e = sbq.pop_front();
          res[wr_addr] = wr_data;
          chk("wr_addr", wr_addr == e.addr,
              wr_addr, e.addr);
          chk("wr_data", wr_data == e.data,
              wr_data, e.data);
          chk("rd_wr_lat", cyc - e.cyc == 2,
              cyc - e.cyc, 2);
        end
      end
      if (busy) begin
        if (n_busy == 0) busy_first = cyc - c0;
        busy_last = cyc - c0;
        n_busy++;
      end
      if (done) begin
        n_done++;
        done_rel = cyc - c0;
      end
    end
  end

  // One complete operation. With now=1 start
  // rises in the current cycle (no extra wait).
  task automatic run_op(input bit now,
                        input int mid);
    bit got;
    if (!now) begin
      @(posedge clk);
      #1;
    end
    clr_mon();
    c0 = cyc;
    start = 1'b1;
    mon = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < TN + 20; k++) begin
      @(posedge clk);
      if (k == mid) #1 start = 1'b1;
      if (k == mid + 1) #1 start = 1'b0;
      if (n_done != 0) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    chk("done_seen", got, got, 1);
    chk("done_cycle", done_rel == TN + 3,
        done_rel, TN + 3);
    chk("done_count", n_done == 1, n_done, 1);
    chk("rd_count", n_rd == TN, n_rd, TN);
    chk("wr_count", n_wr == TN, n_wr, TN);
    chk("busy_first", busy_first == 1,
        busy_first, 1);
    chk("busy_last", busy_last == TN + 2,
        busy_last, TN + 2);
    chk("busy_len", n_busy == TN + 2,
        n_busy, TN + 2);
    chk("sb_empty", sbq.size() == 0,
        sbq.size(), 0);
  endtask

  vec_t tv[6];
  bit   hit;

  initial begin
    tv[0] = '{12'd3328, 12'd1,    12'd0};
    tv[1] = '{12'd3328, 12'd3328, 12'd3327};
    tv[2] = '{12'd1664, 12'd1665, 12'd0};
    tv[3] = '{12'd1664, 12'd1664, 12'd3328};
    tv[4] = '{12'd3000, 12'd328,  12'd3328};
    tv[5] = '{12'd0,    12'd0,    12'd0};
    clr_mon();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {busy, done, rd_en, rd_addr,
        wr_en, wr_addr, wr_data} == 32'd0,
        {busy, done, rd_en, rd_addr,
        wr_en, wr_addr, wr_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outs", {busy, done, rd_en, rd_addr,
        wr_en} == 12'd0,
        {busy, done, rd_en, rd_addr, wr_en}, 0);

    // Identity: A[i]=i, B[i]=0.
    for (int i = 0; i < TN; i++) begin
      mem_a[i] = 12'(i);
      mem_b[i] = 12'd0;
      mem_e[i] = 12'(i);
    end
    run_op(1'b0, -1);

    // Boundary table.
    for (int i = 0; i < TN; i++) begin
      mem_a[i] = tv[i % 6].a;
      mem_b[i] = tv[i % 6].b;
      mem_e[i] = tv[i % 6].e;
    end
    run_op(1'b0, -1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("tbl%0d", k),
          res[k] == tv[k].e, res[k], tv[k].e);
    end

    // Random operands below Q.
    for (int i = 0; i < TN; i++) begin
      mem_a[i] = 12'($urandom_range(QI - 1));
      mem_b[i] = 12'($urandom_range(QI - 1));
      mem_e[i] = 12'((int'(mem_a[i]) +
                      int'(mem_b[i])) % QI);
    end
    run_op(1'b0, -1);

    // Mid-run start ignored, then a start in
    // the cycle right after done.
    run_op(1'b0, 50);
    run_op(1'b1, -1);

    // start held for 300 cycles.
    @(posedge clk);
    #1;
    clr_mon();
    c0 = cyc;
    start = 1'b1;
    repeat (300) @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("held_done", n_done == 1, n_done, 1);
    chk("held_rd", n_rd == TN, n_rd, TN);
    chk("held_wr", n_wr == TN, n_wr, TN);

    // Reset during read 100.
    clr_mon();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (rd_en && rd_addr == 8'd100) begin
        hit = 1'b1;
        break;
      end
    end
    chk("rd100_seen", hit, hit, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_outs", {busy, done, rd_en, rd_addr,
        wr_en, wr_addr, wr_data} == 32'd0,
        {busy, done, rd_en, rd_addr,
        wr_en, wr_addr, wr_data}, 0);
    sbq.delete();
    n_done = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("abort_nodone", n_done == 0, n_done, 0);
    chk("abort_nowr", sbq.size() == 0,
        sbq.size(), 0);
    run_op(1'b0, -1);
    chk("post_rst_a0", res[0] == mem_e[0],
        res[0], mem_e[0]);
    mon = 1'b0;

    // N=4 build, cycle by cycle.
    @(posedge clk);
    #1 start4 = 1'b1;
    for (int r = 0; r <= 8; r++) begin
      @(negedge clk);
      if (r == 1) start4 = 1'b0;
      chk($sformatf("n4_rd_en@%0d", r),
          rd_en4 == (r >= 1 && r <= 4),
          rd_en4, (r >= 1 && r <= 4));
      if (r >= 1 && r <= 4)
        chk($sformatf("n4_rd_addr@%0d", r),
            rd_addr4 == 2'(r - 1),
            rd_addr4, r - 1);
      chk($sformatf("n4_wr_en@%0d", r),
          wr_en4 == (r >= 3 && r <= 6),
          wr_en4, (r >= 3 && r <= 6));
      if (r >= 3 && r <= 6) begin
        chk($sformatf("n4_wr_addr@%0d", r),
            wr_addr4 == 2'(r - 3),
            wr_addr4, r - 3);
        chk($sformatf("n4_wr_data@%0d", r),
            wr_data4 == mem_e[r - 3],
            wr_data4, mem_e[r - 3]);
      end
      chk($sformatf("n4_done@%0d", r),
          done4 == (r == 7), done4, (r == 7));
      chk($sformatf("n4_busy@%0d", r),
          busy4 == (r >= 1 && r <= 6),
          busy4, (r >= 1 && r <= 6));
    end
    chk("n4_rd_addr_idle", rd_addr4 == 2'd0,
        rd_addr4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
